// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CHK     = 3'd5,
    S_RUN     = 3'd6,
    S_ERR     = 3'd7
  } state_e;

  localparam int          LEN_BYTES = 2;
  localparam logic [7:0]  CHK_SEED  = 8'h00;
  localparam logic [15:0] FETCH_OOR = 16'h0000;

  // States in which the byte stream is being consumed.
  function automatic logic is_loading(state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
           (s == S_DATA_LO) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready port feeding the program loader.
interface imem_loader_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/imem_ram.sv
// Single write port, asynchronous read RAM; contents are not reset.
module imem_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a length-framed, XOR-checksummed byte image into
// instruction RAM, holds the core in reset while loading, then serves fetches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int imem_size = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_start,
  imem_loader_if.slave        ld,
  input  logic [15:0]         imem_addr,
  output logic [15:0]         imem_rdata,
  output logic                core_rst_n,
  output logic                load_done,
  output logic                load_err
);

  localparam int AW = $clog2(imem_size);

  state_e        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    xor_q, xor_d;
  logic          ld_ready_q, ld_ready_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          load_done_q, load_done_d;
  logic          load_err_q, load_err_d;
  logic          accept;
  logic          ram_we;
  logic [15:0]   ram_rdata;
  logic [15:0]   len_rx;
  logic [15:0]   wptr_ext;

  assign accept   = ld.ld_valid && ld_ready_q;
  assign len_rx   = {len_q[15:8], ld.ld_data};
  assign wptr_ext = 16'(wptr_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    hi_d    = hi_q;
    xor_d   = xor_q;
    ram_we  = 1'b0;
    // A restart wins over any byte presented in the same cycle.
    if (ld_start) begin
      state_d = S_LEN_HI;
      wptr_d  = '0;
      xor_d   = CHK_SEED;
    end else if (accept) begin
      xor_d = xor_q ^ ld.ld_data;
      case (state_q)
        S_LEN_HI: begin
          len_d[15:8] = ld.ld_data;
          state_d     = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d   = len_rx;
          state_d = (len_rx == 16'd0 || len_rx > 16'(imem_size)) ? S_ERR : S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = ld.ld_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          ram_we  = 1'b1;
          wptr_d  = wptr_q + 1'b1;
          state_d = (wptr_ext == len_q - 16'd1) ? S_CHK : S_DATA_HI;
        end
        S_CHK:   state_d = (ld.ld_data == xor_q) ? S_RUN : S_ERR;
        default: ;
      endcase
    end
  end

  // Status outputs are registered decodes of the next state.
  always_comb begin
    ld_ready_d   = is_loading(state_d);
    core_rst_n_d = (state_d == S_RUN);
    load_done_d  = (state_d == S_RUN);
    load_err_d   = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      wptr_q       <= '0;
      hi_q         <= '0;
      xor_q        <= CHK_SEED;
      ld_ready_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wptr_q       <= wptr_d;
      hi_q         <= hi_d;
      xor_q        <= xor_d;
      ld_ready_q   <= ld_ready_d;
      core_rst_n_q <= core_rst_n_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  imem_ram #(
    .DEPTH (imem_size),
    .WIDTH (16)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr_q[AW-1:0]),
    .wdata ({hi_q, ld.ld_data}),
    .raddr (imem_addr[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign imem_rdata  = (imem_addr < 16'(imem_size)) ? ram_rdata : FETCH_OOR;
  assign ld.ld_ready = ld_ready_q;
  assign core_rst_n  = core_rst_n_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed images with hand-computed checksums.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_start = 1'b0;
  logic [15:0] imem_addr = 16'h0;
  logic [15:0] imem_rdata;
  logic        core_rst_n, load_done, load_err;

  imem_loader_if ld_if ();

  imem_loader #(.imem_size(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_start   (ld_start),
    .ld         (ld_if),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] fetch_q [$];
  logic [3:0]  status_q [$];   // {core_rst_n, load_done, load_err, ld_ready}
  logic        fetch_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: fetch results when requested, status whenever done/err rises.
  logic [1:0] prev_evt = 2'b00;
  always @(negedge clk) begin
    logic [1:0] cur;
    if (fetch_req) begin
      if (fetch_q.size() == 0) check("fetch_q_underflow", 32'd1, 32'd0);
      else check("fetch_rdata", 32'(imem_rdata), 32'(fetch_q.pop_front()));
    end
    cur = {load_done, load_err};
    if ((cur & ~prev_evt) != 2'b00) begin
      if (status_q.size() == 0) check("status_q_underflow", 32'd1, 32'd0);
      else check("status", 32'({core_rst_n, load_done, load_err, ld_if.ld_ready}),
                 32'(status_q.pop_front()));
    end
    prev_evt = cur;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input logic [15:0] addr, input logic [15:0] exp);
    @(posedge clk); #1;
    imem_addr = addr;
    fetch_q.push_back(exp);
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned k;
    @(negedge clk);
    if (gaps) begin
      ld_if.ld_valid = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = b;
    k = 0;
    while (!ld_if.ld_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("ld_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    ld_start = 1'b1;
    if (with_byte) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = b;
    end
    @(posedge clk); #1;
    ld_start = 1'b0;
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic send_image(input logic [15:0] words [$], input logic [7:0] chk,
                            input bit gaps, input bit exp_run);
    logic [15:0] n;
    n = 16'(words.size());
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    foreach (words[i]) begin
      send_byte(words[i][15:8], gaps);
      send_byte(words[i][7:0], gaps);
    end
    check("core_rst_n_before_chk", 32'(core_rst_n), 32'd0);
    send_byte(chk, gaps);
    check("core_rst_n_after_chk", 32'(core_rst_n), 32'(exp_run));
  endtask

  logic [15:0] img3 [$];
  logic [15:0] img32 [$];
  logic [15:0] img1 [$];

  initial begin
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 8'h00;
    img3  = '{16'h1234, 16'hABCD, 16'h0F0F};
    img1  = '{16'hBEEF};
    for (int i = 0; i < 32; i++) img32.push_back({8'(8'hA0 + i), 8'(8'hA0 + i)});

    // Reset state
    #12;
    check("rst_ld_ready", 32'(ld_if.ld_ready), 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    rst_n = 1'b1;
    fetch(16'h0040, 16'h0000);

    // Good N=3 image, back-to-back; checksum 0x43
    pulse_start(1'b0, 8'h00);
    status_q.push_back(4'b1100);
    send_image(img3, 8'h43, 1'b0, 1'b1);
    fetch(16'd0, 16'h1234);
    fetch(16'd1, 16'hABCD);
    fetch(16'd2, 16'h0F0F);
    fetch(16'd32, 16'h0000);

    // Same image, checksum off by one
    pulse_start(1'b0, 8'h00);
    check("run_restart_core_rst_n", 32'(core_rst_n), 32'd0);
    status_q.push_back(4'b0010);
    send_image(img3, 8'h42, 1'b0, 1'b0);
    fetch(16'd1, 16'hABCD);

    // LEN = 0
    pulse_start(1'b0, 8'h00);
    status_q.push_back(4'b0010);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("len0_err", 32'(load_err), 32'd1);
    check("len0_ready", 32'(ld_if.ld_ready), 32'd0);

    // LEN = imem_size + 1
    pulse_start(1'b0, 8'h00);
    status_q.push_back(4'b0010);
    send_byte(8'h00, 1'b0);
    send_byte(8'h21, 1'b0);
    check("len33_err", 32'(load_err), 32'd1);
    fetch(16'd0, 16'h1234);

    // Full-size image N=32 (hi==lo bytes cancel, checksum = 0x00^0x20)
    pulse_start(1'b0, 8'h00);
    status_q.push_back(4'b1100);
    send_image(img32, 8'h20, 1'b0, 1'b1);
    fetch(16'd0, 16'hA0A0);
    fetch(16'd31, 16'hBFBF);

    // N=3 image with random gaps; words beyond N keep old contents
    pulse_start(1'b0, 8'h00);
    status_q.push_back(4'b1100);
    send_image(img3, 8'h43, 1'b1, 1'b1);
    fetch(16'd0, 16'h1234);
    fetch(16'd2, 16'h0F0F);
    fetch(16'd3, 16'hA3A3);

    // Restart mid-DATA with a simultaneous byte, then N=1 image; checksum 0x50
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    pulse_start(1'b1, 8'h22);
    status_q.push_back(4'b1100);
    send_image(img1, 8'h50, 1'b0, 1'b1);
    check("n1_load_done", 32'(load_done), 32'd1);
    fetch(16'd0, 16'hBEEF);
    fetch(16'd1, 16'hABCD);

    // ld_start in RUN drops core reset on the next edge
    pulse_start(1'b0, 8'h00);
    check("reload_core_rst_n", 32'(core_rst_n), 32'd0);
    check("reload_load_done", 32'(load_done), 32'd0);
    check("reload_ld_ready", 32'(ld_if.ld_ready), 32'd1);

    // Asynchronous reset during DATA_LO
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hAA, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("arst_ld_ready", 32'(ld_if.ld_ready), 32'd0);
    fetch(16'h0040, 16'h0000);
    rst_n = 1'b1;

    repeat (4) @(posedge clk);
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("status_q_drained", 32'(status_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
